// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline
// (fetch, decode, execute, memory, writeback). It drives the PC enable and
// the enable/flush of the four pipeline latches FD, DE, EM and MW.
// It handles load-use bubbles (LU_BUBBLES deep), dcache and icache stalls,
// branch/jump redirects resolved in decode or execute, and a sticky halt.
// It also keeps a saturating count of stalled cycles.
module pipeline_hazard_ctrl #(
  parameter int REGW       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int BR_STAGE   = 2,
  parameter int CNTW       = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            dREN,
  input  logic            dWEN,
  input  logic            de_memread,
  input  logic [REGW-1:0] de_rd,
  input  logic [REGW-1:0] fd_rs,
  input  logic [REGW-1:0] fd_rt,
  input  logic            fd_uses_rs,
  input  logic            fd_uses_rt,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            halt_wb,
  output logic            pc_en,
  output logic [3:0]      lat_en,
  output logic [3:0]      lat_flush,
  output logic            halted,
  output logic [CNTW-1:0] stall_cycles
);

  // Width of the bubble down-counter; LU_BUBBLES is limited to 1..3.
  localparam int              LCW       = $clog2(LU_BUBBLES + 1);
  localparam logic [LCW-1:0]  LU_RELOAD = LCW'(LU_BUBBLES - 1);

  // Latch vectors, bit0=FD .. bit3=MW.
  localparam logic [3:0] EN_ALL    = 4'b1111;
  localparam logic [3:0] EN_HOLDFD = 4'b1110;
  localparam logic [3:0] FL_NONE   = 4'b0000;
  localparam logic [3:0] FL_FD     = 4'b0001;
  localparam logic [3:0] FL_DE     = 4'b0010;
  localparam logic [3:0] FL_FDDE   = 4'b0011;

  // Reject out-of-range configurations at elaboration.
  generate
    if (LU_BUBBLES < 1 || LU_BUBBLES > 3) begin : g_bad_lu
      $error("pipeline_hazard_ctrl: LU_BUBBLES must be 1..3");
    end
    if (BR_STAGE != 1 && BR_STAGE != 2) begin : g_bad_br
      $error("pipeline_hazard_ctrl: BR_STAGE must be 1 or 2");
    end
    if (CNTW < 1) begin : g_bad_cnt
      $error("pipeline_hazard_ctrl: CNTW must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LUSTALL = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LCW-1:0]  r_lu_cnt;
  logic [LCW-1:0]  w_lu_cnt_nxt;
  logic            r_halted;
  logic [CNTW-1:0] r_stall_cnt;

  logic            w_mem_ok;
  logic            w_lu_hit;
  logic            w_br_late;
  logic            w_redirect_early;
  logic            w_pc_en;
  logic [3:0]      w_lat_en;
  logic [3:0]      w_lat_flush;

  // A data access in flight without a dcache hit freezes the whole pipe.
  assign w_mem_ok = ~(~dhit & (dREN | dWEN));

  // The load in execute writes a register that decode is about to read.
  // Register 0 never carries a dependency.
  assign w_lu_hit = de_memread & (de_rd != '0) &
                    ((fd_uses_rs & (fd_rs == de_rd)) |
                     (fd_uses_rt & (fd_rt == de_rd)));

  // Branches resolved in execute must also squash the decode-stage
  // instruction, and they outrank load-use. Branches resolved in decode
  // rank like jumps, below load-use.
  assign w_br_late        = (BR_STAGE == 2) & branch_taken;
  assign w_redirect_early = jump | ((BR_STAGE == 1) & branch_taken);

  // Next-state and latch control; all outputs stay low while in reset,
  // while halted, or while the data memory is stalling.
  always_comb begin
    w_state_nxt  = r_state;
    w_lu_cnt_nxt = r_lu_cnt;
    w_pc_en      = 1'b0;
    w_lat_en     = '0;
    w_lat_flush  = FL_NONE;
    if (!RST && (r_state != HALTED) && w_mem_ok) begin
      if (w_br_late) begin
        // Redirect from execute: drop FD and DE, cancel any bubble train.
        w_pc_en      = 1'b1;
        w_lat_en     = EN_ALL;
        w_lat_flush  = FL_FDDE;
        w_state_nxt  = RUN;
        w_lu_cnt_nxt = '0;
      end else if ((r_state == LUSTALL) || w_lu_hit) begin
        // Hold PC and FD, inject a bubble into DE, let the load advance.
        w_pc_en     = 1'b0;
        w_lat_en    = EN_HOLDFD;
        w_lat_flush = FL_DE;
        if (r_state == LUSTALL) begin
          w_lu_cnt_nxt = r_lu_cnt - LCW'(1);
          if (r_lu_cnt <= LCW'(1)) begin
            w_state_nxt = RUN;
          end
        end else if (LU_BUBBLES > 1) begin
          w_state_nxt  = LUSTALL;
          w_lu_cnt_nxt = LU_RELOAD;
        end
      end else begin
        w_pc_en  = 1'b1;
        w_lat_en = EN_ALL;
        if (w_redirect_early) begin
          // The fetched instruction is on the wrong path.
          w_lat_flush = FL_FD;
        end else if (!ihit) begin
          // No instruction yet: keep the PC and feed a bubble into FD.
          w_pc_en     = 1'b0;
          w_lat_flush = FL_FD;
        end
      end
      // Halt leaves writeback only once memory is quiet; it overrides all.
      if (halt_wb) begin
        w_state_nxt = HALTED;
      end
    end
  end

  // Controller state, bubble counter and halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= RUN;
      r_lu_cnt <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
      r_halted <= (w_state_nxt == HALTED);
    end
  end

  // Count cycles where the PC did not advance in a live core; saturate.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if ((r_state != HALTED) && !w_pc_en && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pc_en        = w_pc_en;
  assign lat_en       = w_lat_en;
  assign lat_flush    = w_lat_flush;
  assign halted       = r_halted;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Three controllers with different
// configurations share one stimulus stream. A behavioural model predicts
// every cycle's outputs; predictions go into a queue and a monitor process
// compares them against the DUTs.
module tb_pipeline_hazard_ctrl;

  localparam int NI = 3;

  function automatic int lu_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 3 : 1;
  endfunction
  function automatic int br_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction
  function automatic int cw_of(input int g);
    return (g == 1) ? 4 : 32;
  endfunction

  typedef struct packed {
    logic       rst, ihit, dhit, dren, dwen, memread;
    logic [4:0] de_rd, rs, rt;
    logic       urs, urt, bt, jmp, hwb;
  } stim_t;

  typedef struct packed {
    logic [NI-1:0]       pc;
    logic [NI-1:0][3:0]  en;
    logic [NI-1:0][3:0]  fl;
    logic [NI-1:0]       hl;
    logic [NI-1:0][31:0] cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ihit = 1'b1, dhit = 1'b1, dREN = 1'b0, dWEN = 1'b0;
  logic       de_memread = 1'b0;
  logic [4:0] de_rd = '0, fd_rs = '0, fd_rt = '0;
  logic       fd_uses_rs = 1'b0, fd_uses_rt = 1'b0;
  logic       branch_taken = 1'b0, jump = 1'b0, halt_wb = 1'b0;

  logic [NI-1:0]       a_pc, a_hl;
  logic [NI-1:0][3:0]  a_en, a_fl;
  logic [NI-1:0][31:0] a_cnt;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;

  // Model state: extra bubbles still owed, halt flag, stall count.
  int     m_bub[NI];
  bit     m_halt[NI];
  longint m_cnt[NI];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = cw_of(g);
    logic [CW-1:0] c;
    pipeline_hazard_ctrl #(
      .REGW(5), .LU_BUBBLES(lu_of(g)), .BR_STAGE(br_of(g)), .CNTW(CW)
    ) u_dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
      .de_memread(de_memread), .de_rd(de_rd), .fd_rs(fd_rs), .fd_rt(fd_rt),
      .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
      .branch_taken(branch_taken), .jump(jump), .halt_wb(halt_wb),
      .pc_en(a_pc[g]), .lat_en(a_en[g]), .lat_flush(a_fl[g]),
      .halted(a_hl[g]), .stall_cycles(c)
    );
    assign a_cnt[g] = 32'(c);
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    s.dhit = 1'b1;
    return s;
  endfunction

  // Predict this cycle's outputs from the rules, then advance the model
  // to what the coming clock edge should leave behind.
  task automatic model(input stim_t s, output exp_t e);
    e = '0;
    for (int g = 0; g < NI; g++) begin
      int         lu;
      int         br;
      longint     mx;
      bit         memok, luhit, pc;
      logic [3:0] en, fl;
      lu = lu_of(g);
      br = br_of(g);
      mx = (64'd1 << cw_of(g)) - 1;
      if (s.rst) begin
        m_bub[g]  = 0;
        m_halt[g] = 0;
        m_cnt[g]  = 0;
        continue;
      end
      e.hl[g]  = m_halt[g];
      e.cnt[g] = 32'(m_cnt[g]);
      memok = s.dhit || !(s.dren || s.dwen);
      luhit = s.memread && (s.de_rd != 0) &&
              ((s.urs && s.rs == s.de_rd) || (s.urt && s.rt == s.de_rd));
      pc = 0; en = 4'b0000; fl = 4'b0000;
      if (m_halt[g] || !memok) begin
        pc = 0;
      end else if (br == 2 && s.bt) begin
        pc = 1; en = 4'b1111; fl = 4'b0011; m_bub[g] = 0;
      end else if (m_bub[g] > 0 || luhit) begin
        en = 4'b1110; fl = 4'b0010;
        if (m_bub[g] > 0) m_bub[g]--;
        else m_bub[g] = lu - 1;
      end else begin
        pc = 1; en = 4'b1111;
        if (s.jmp || (br == 1 && s.bt)) fl = 4'b0001;
        else if (!s.ihit) begin pc = 0; fl = 4'b0001; end
      end
      if (!m_halt[g] && !pc && m_cnt[g] < mx) m_cnt[g]++;
      if (!m_halt[g] && memok && s.hwb) m_halt[g] = 1;
      e.pc[g] = pc;
      e.en[g] = en;
      e.fl[g] = fl;
    end
  endtask

  // Apply one cycle of stimulus just after the falling edge and queue the
  // predicted response.
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge CLK);
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; dREN = s.dren; dWEN = s.dwen;
    de_memread = s.memread; de_rd = s.de_rd; fd_rs = s.rs; fd_rt = s.rt;
    fd_uses_rs = s.urs; fd_uses_rt = s.urt; branch_taken = s.bt;
    jump = s.jmp; halt_wb = s.hwb;
    #1;
    model(s, e);
    sb_q.push_back(e);
  endtask

  task automatic steps(input stim_t s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  function automatic stim_t hazard();
    stim_t s;
    s = idle();
    s.memread = 1'b1;
    s.de_rd   = 5'd8;
    s.rs      = 5'd8;
    s.urs     = 1'b1;
    return s;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h",
               nm, g, cyc, act, expv);
    end
  endtask

  // Monitor: compare queued predictions against the DUTs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int g = 0; g < NI; g++) begin
          chk("pc_en",        g, 32'(a_pc[g]), 32'(e.pc[g]));
          chk("lat_en",       g, 32'(a_en[g]), 32'(e.en[g]));
          chk("lat_flush",    g, 32'(a_fl[g]), 32'(e.fl[g]));
          chk("halted",       g, 32'(a_hl[g]), 32'(e.hl[g]));
          chk("stall_cycles", g, a_cnt[g],     e.cnt[g]);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cyc;
    // Reset.
    s = idle(); s.rst = 1'b1;
    steps(s, 2);
    // Load-use bubble train, then idle.
    step(hazard());
    steps(idle(), 4);
    // Load from r0 is never a hazard.
    s = hazard(); s.de_rd = 5'd0; s.rs = 5'd0;
    steps(s, 2);
    // Hazard through rt only.
    s = hazard(); s.urs = 1'b0; s.rs = 5'd3; s.rt = 5'd8; s.urt = 1'b1;
    step(s);
    steps(idle(), 4);
    // Load-use with a 4-cycle dcache stall in the middle of the bubbles.
    step(hazard());
    s = idle(); s.dren = 1'b1; s.dhit = 1'b0;
    steps(s, 4);
    steps(idle(), 4);
    // Taken branch coincident with a load-use hazard.
    s = hazard(); s.bt = 1'b1;
    step(s);
    steps(idle(), 4);
    // Jump coincident with a load-use hazard.
    s = hazard(); s.jmp = 1'b1;
    step(s);
    steps(idle(), 4);
    // Reset during the second bubble of a train.
    step(hazard());
    step(idle());
    s = idle(); s.rst = 1'b1;
    step(s);
    steps(idle(), 3);
    // Three icache misses, then halt; the core must stay frozen.
    s = idle(); s.ihit = 1'b0;
    steps(s, 3);
    s = idle(); s.hwb = 1'b1;
    step(s);
    s = idle(); s.ihit = 1'b0;
    steps(s, 3);
    step(hazard());
    steps(idle(), 2);
    s = idle(); s.rst = 1'b1;
    step(s);
    // Long icache miss to saturate the narrow counter.
    s = idle(); s.ihit = 1'b0;
    steps(s, 20);
    steps(idle(), 2);
    // Randomised traffic with occasional halts and resets.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst     = ($urandom_range(0, 120) == 0);
      s.ihit    = ($urandom_range(0, 5) != 0);
      s.dhit    = ($urandom_range(0, 3) != 0);
      s.dren    = ($urandom_range(0, 3) == 0);
      s.dwen    = ($urandom_range(0, 7) == 0);
      s.memread = 1'($urandom_range(0, 1));
      s.de_rd   = 5'($urandom_range(0, 3));
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.urs     = 1'($urandom_range(0, 1));
      s.urt     = 1'($urandom_range(0, 1));
      s.bt      = ($urandom_range(0, 5) == 0);
      s.jmp     = ($urandom_range(0, 7) == 0);
      s.hwb     = ($urandom_range(0, 150) == 0);
      step(s);
    end
    // Let the monitor drain the queue, bounded.
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge CLK);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
